// File: rtl/raytracer_top.sv
// Voxel ray-traversal engine: 32x32x32 occupancy memory walked by a 3D-DDA stepper.
module raytracer_top #(
  parameter int unsigned COORD_WIDTH      = 16,
  parameter int unsigned COORD_W          = 6,
  parameter int unsigned TIMER_WIDTH      = 32,
  parameter int unsigned W                = 32,
  parameter int unsigned MAX_VAL          = 31,
  parameter int unsigned ADDR_BITS        = 15,
  parameter int unsigned X_BITS           = 6,
  parameter int unsigned Y_BITS           = 6,
  parameter int unsigned Z_BITS           = 6,
  parameter int unsigned MAX_STEPS_BITS   = 10,
  parameter int unsigned STEP_COUNT_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        job_valid,
  output logic                        job_ready,
  input  logic [X_BITS-1:0]           job_ix0,
  input  logic [Y_BITS-1:0]           job_iy0,
  input  logic [Z_BITS-1:0]           job_iz0,
  input  logic                        job_sx,
  input  logic                        job_sy,
  input  logic                        job_sz,
  input  logic [W-1:0]                job_next_x,
  input  logic [W-1:0]                job_next_y,
  input  logic [W-1:0]                job_next_z,
  input  logic [W-1:0]                job_inc_x,
  input  logic [W-1:0]                job_inc_y,
  input  logic [W-1:0]                job_inc_z,
  input  logic [MAX_STEPS_BITS-1:0]   job_max_steps,
  input  logic                        load_mode,
  input  logic                        load_valid,
  output logic                        load_ready,
  input  logic [ADDR_BITS-1:0]        load_addr,
  input  logic                        load_data,
  output logic [ADDR_BITS:0]          write_count,
  output logic                        load_complete,
  output logic                        ray_done,
  output logic                        ray_hit,
  output logic                        ray_timeout,
  output logic [COORD_WIDTH-1:0]      hit_voxel_x,
  output logic [COORD_WIDTH-1:0]      hit_voxel_y,
  output logic [COORD_WIDTH-1:0]      hit_voxel_z,
  output logic [2:0]                  hit_face_id,
  output logic [STEP_COUNT_WIDTH-1:0] steps_taken
);

  localparam int unsigned AXIS_BITS = ADDR_BITS / 3;
  localparam int unsigned DEPTH     = 1 << ADDR_BITS;

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_CHECK, S_STEP, S_DONE} state_t;

  state_t                      state_q;
  logic [COORD_W-1:0]          x_q, y_q, z_q;
  logic                        sx_q, sy_q, sz_q;
  logic [TIMER_WIDTH-1:0]      tx_q, ty_q, tz_q;
  logic [TIMER_WIDTH-1:0]      ix_q, iy_q, iz_q;
  logic [MAX_STEPS_BITS-1:0]   max_q;
  logic [STEP_COUNT_WIDTH-1:0] cnt_q;
  logic [2:0]                  face_q;
  logic                        done_q, hit_q, timeout_q;
  logic [COORD_WIDTH-1:0]      hx_q, hy_q, hz_q;
  logic [2:0]                  hface_q;
  logic                        lm_q;
  logic [ADDR_BITS:0]          wcnt_q;

  logic                        mem_q [0:DEPTH-1];
  logic                        solid_q;

  logic [COORD_W-1:0]          x_d, y_d, z_d;
  logic [TIMER_WIDTH-1:0]      tx_d, ty_d, tz_d;
  logic [2:0]                  face_d;
  logic                        oob_d;
  logic                        load_acc;
  logic                        start_oob;
  logic [ADDR_BITS-1:0]        rd_addr;

  assign job_ready     = (state_q == S_IDLE) && !load_mode;
  assign load_ready    = load_mode && (state_q == S_IDLE);
  assign load_acc      = load_valid && load_ready;
  assign write_count   = wcnt_q;
  assign load_complete = wcnt_q[ADDR_BITS];
  assign ray_done      = done_q;
  assign ray_hit       = hit_q;
  assign ray_timeout   = timeout_q;
  assign hit_voxel_x   = hx_q;
  assign hit_voxel_y   = hy_q;
  assign hit_voxel_z   = hz_q;
  assign hit_face_id   = hface_q;
  assign steps_taken   = cnt_q;

  assign rd_addr   = {z_q[AXIS_BITS-1:0], y_q[AXIS_BITS-1:0], x_q[AXIS_BITS-1:0]};
  assign start_oob = (COORD_W'(job_ix0) > COORD_W'(MAX_VAL)) ||
                     (COORD_W'(job_iy0) > COORD_W'(MAX_VAL)) ||
                     (COORD_W'(job_iz0) > COORD_W'(MAX_VAL));

  function automatic logic [TIMER_WIDTH-1:0] sat_add(input logic [TIMER_WIDTH-1:0] a,
                                                     input logic [TIMER_WIDTH-1:0] b);
    logic [TIMER_WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[TIMER_WIDTH] ? {TIMER_WIDTH{1'b1}} : s[TIMER_WIDTH-1:0];
  endfunction

  // DDA step candidate: advance the axis with the smallest timer, ties X > Y > Z
  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    z_d    = z_q;
    tx_d   = tx_q;
    ty_d   = ty_q;
    tz_d   = tz_q;
    face_d = face_q;
    if ((tx_q <= ty_q) && (tx_q <= tz_q)) begin
      x_d    = sx_q ? x_q + COORD_W'(1) : x_q - COORD_W'(1);
      tx_d   = sat_add(tx_q, ix_q);
      face_d = sx_q ? 3'd0 : 3'd1;
    end else if (ty_q <= tz_q) begin
      y_d    = sy_q ? y_q + COORD_W'(1) : y_q - COORD_W'(1);
      ty_d   = sat_add(ty_q, iy_q);
      face_d = sy_q ? 3'd2 : 3'd3;
    end else begin
      z_d    = sz_q ? z_q + COORD_W'(1) : z_q - COORD_W'(1);
      tz_d   = sat_add(tz_q, iz_q);
      face_d = sz_q ? 3'd4 : 3'd5;
    end
    oob_d = (x_d > COORD_W'(MAX_VAL)) || (y_d > COORD_W'(MAX_VAL)) ||
            (z_d > COORD_W'(MAX_VAL));
  end

  // Occupancy memory: host writes, synchronous read during FETCH
  always_ff @(posedge clk) begin
    if (load_acc) mem_q[load_addr] <= load_data;
    if (state_q == S_FETCH) solid_q <= mem_q[rd_addr];
  end

  // Scene-load write counter, restarted on each rising edge of load_mode
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lm_q   <= 1'b0;
      wcnt_q <= '0;
    end else begin
      lm_q <= load_mode;
      if (load_mode && !lm_q)
        wcnt_q <= load_acc ? (ADDR_BITS+1)'(1) : '0;
      else if (load_acc && !wcnt_q[ADDR_BITS])
        wcnt_q <= wcnt_q + (ADDR_BITS+1)'(1);
    end
  end

  // Traversal FSM with registered result outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      x_q       <= '0;
      y_q       <= '0;
      z_q       <= '0;
      sx_q      <= 1'b0;
      sy_q      <= 1'b0;
      sz_q      <= 1'b0;
      tx_q      <= '0;
      ty_q      <= '0;
      tz_q      <= '0;
      ix_q      <= '0;
      iy_q      <= '0;
      iz_q      <= '0;
      max_q     <= '0;
      cnt_q     <= '0;
      face_q    <= 3'd6;
      done_q    <= 1'b0;
      hit_q     <= 1'b0;
      timeout_q <= 1'b0;
      hx_q      <= '0;
      hy_q      <= '0;
      hz_q      <= '0;
      hface_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (job_valid && job_ready) begin
            x_q       <= COORD_W'(job_ix0);
            y_q       <= COORD_W'(job_iy0);
            z_q       <= COORD_W'(job_iz0);
            sx_q      <= job_sx;
            sy_q      <= job_sy;
            sz_q      <= job_sz;
            tx_q      <= TIMER_WIDTH'(job_next_x);
            ty_q      <= TIMER_WIDTH'(job_next_y);
            tz_q      <= TIMER_WIDTH'(job_next_z);
            ix_q      <= TIMER_WIDTH'(job_inc_x);
            iy_q      <= TIMER_WIDTH'(job_inc_y);
            iz_q      <= TIMER_WIDTH'(job_inc_z);
            max_q     <= job_max_steps;
            cnt_q     <= '0;
            face_q    <= 3'd6;
            hit_q     <= 1'b0;
            timeout_q <= 1'b0;
            hface_q   <= '0;
            if (start_oob) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_FETCH;
            end
          end
        end
        S_FETCH: state_q <= S_CHECK;
        S_CHECK: begin
          if (solid_q) begin
            hit_q   <= 1'b1;
            hx_q    <= COORD_WIDTH'(x_q);
            hy_q    <= COORD_WIDTH'(y_q);
            hz_q    <= COORD_WIDTH'(z_q);
            hface_q <= face_q;
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else if (cnt_q == STEP_COUNT_WIDTH'(max_q)) begin
            timeout_q <= 1'b1;
            state_q   <= S_DONE;
            done_q    <= 1'b1;
          end else begin
            state_q <= S_STEP;
          end
        end
        S_STEP: begin
          x_q    <= x_d;
          y_q    <= y_d;
          z_q    <= z_d;
          tx_q   <= tx_d;
          ty_q   <= ty_d;
          tz_q   <= tz_d;
          face_q <= face_d;
          cnt_q  <= cnt_q + STEP_COUNT_WIDTH'(1);
          if (oob_d) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else begin
            state_q <= S_FETCH;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_raytracer_top.sv
// Scoreboard bench for raytracer_top: directed scenes and rays with hand-computed results.
module tb_raytracer_top;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        job_valid, job_ready;
  logic [5:0]  job_ix0, job_iy0, job_iz0;
  logic        job_sx, job_sy, job_sz;
  logic [31:0] job_next_x, job_next_y, job_next_z;
  logic [31:0] job_inc_x, job_inc_y, job_inc_z;
  logic [9:0]  job_max_steps;
  logic        load_mode, load_valid, load_ready;
  logic [14:0] load_addr;
  logic        load_data;
  logic [15:0] write_count;
  logic        load_complete;
  logic        ray_done, ray_hit, ray_timeout;
  logic [15:0] hit_voxel_x, hit_voxel_y, hit_voxel_z;
  logic [2:0]  hit_face_id;
  logic [15:0] steps_taken;

  always #5 clk = ~clk;

  raytracer_top dut (
    .clk(clk), .rst_n(rst_n),
    .job_valid(job_valid), .job_ready(job_ready),
    .job_ix0(job_ix0), .job_iy0(job_iy0), .job_iz0(job_iz0),
    .job_sx(job_sx), .job_sy(job_sy), .job_sz(job_sz),
    .job_next_x(job_next_x), .job_next_y(job_next_y), .job_next_z(job_next_z),
    .job_inc_x(job_inc_x), .job_inc_y(job_inc_y), .job_inc_z(job_inc_z),
    .job_max_steps(job_max_steps),
    .load_mode(load_mode), .load_valid(load_valid), .load_ready(load_ready),
    .load_addr(load_addr), .load_data(load_data),
    .write_count(write_count), .load_complete(load_complete),
    .ray_done(ray_done), .ray_hit(ray_hit), .ray_timeout(ray_timeout),
    .hit_voxel_x(hit_voxel_x), .hit_voxel_y(hit_voxel_y), .hit_voxel_z(hit_voxel_z),
    .hit_face_id(hit_face_id), .steps_taken(steps_taken)
  );

  typedef struct {
    int  id;
    bit  hit;
    bit  to;
    int  hx, hy, hz;
    int  face;
    int  steps;
    int  lat;
    time tacc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   done_cnt = 0;
  int   job_id   = 0;

  task automatic chk(input string nm, input int act, input int expv);
    n_checks++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, expv);
  endtask

  function automatic int va(input int x, input int y, input int z);
    return z * 1024 + y * 32 + x;
  endfunction

  // Monitor: every ray_done pulse is matched against the oldest expected result
  always @(negedge clk) begin : mon
    exp_t e;
    int   lat;
    bit   ok;
    if (rst_n && ray_done) begin
      done_cnt++;
      n_checks++;
      if (sb.size() == 0) begin
        $display("FAIL unexpected_ray_done: steps=%0d hit=%0d", steps_taken, ray_hit);
      end else begin
        e   = sb.pop_front();
        lat = int'(($time - e.tacc - 5) / 10);
        ok  = (ray_hit == e.hit) && (ray_timeout == e.to) &&
              (int'(hit_face_id) == e.face) && (int'(steps_taken) == e.steps) &&
              (lat == e.lat);
        if (e.hit)
          ok = ok && (int'(hit_voxel_x) == e.hx) && (int'(hit_voxel_y) == e.hy) &&
               (int'(hit_voxel_z) == e.hz);
        if (ok) n_pass++;
        else $display("FAIL job%0d: got hit=%0d to=%0d v=(%0d,%0d,%0d) face=%0d steps=%0d lat=%0d expected hit=%0d to=%0d v=(%0d,%0d,%0d) face=%0d steps=%0d lat=%0d",
                      e.id, ray_hit, ray_timeout, hit_voxel_x, hit_voxel_y, hit_voxel_z,
                      hit_face_id, steps_taken, lat, e.hit, e.to, e.hx, e.hy, e.hz,
                      e.face, e.steps, e.lat);
      end
    end
  end

  task automatic wr(input int addr, input bit d);
    load_valid = 1'b1;
    load_addr  = 15'(addr);
    load_data  = d;
    @(negedge clk);
  endtask

  // Clears the previous solid voxel and sets the new one in one load session
  task automatic scene(input int a_clr, input int a_set);
    load_mode = 1'b1;
    wr(a_clr, 1'b0);
    wr(a_set, 1'b1);
    load_valid = 1'b0;
    chk("scene_write_count", int'(write_count), 2);
    load_mode = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_job(input int ix, input int iy, input int iz,
                         input bit sx, input bit sy, input bit sz,
                         input logic [31:0] nx, input logic [31:0] ny, input logic [31:0] nz,
                         input logic [31:0] dx, input logic [31:0] dy, input logic [31:0] dz,
                         input int maxs,
                         input bit ehit, input bit eto, input int ex, input int ey, input int ez,
                         input int eface, input int esteps, input int elat);
    exp_t e;
    job_ix0 = 6'(ix); job_iy0 = 6'(iy); job_iz0 = 6'(iz);
    job_sx = sx; job_sy = sy; job_sz = sz;
    job_next_x = nx; job_next_y = ny; job_next_z = nz;
    job_inc_x = dx; job_inc_y = dy; job_inc_z = dz;
    job_max_steps = 10'(maxs);
    job_valid = 1'b1;
    @(posedge clk);
    e.id = job_id; e.hit = ehit; e.to = eto; e.hx = ex; e.hy = ey; e.hz = ez;
    e.face = eface; e.steps = esteps; e.lat = elat; e.tacc = $time;
    sb.push_back(e);
    job_id++;
    #1 job_valid = 1'b0;
    @(negedge clk);
    chk("busy_job_ready", int'(job_ready), 0);
    for (int i = 0; i < 2000 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      n_checks++;
      $display("FAIL job%0d_timeout: got no ray_done expected ray_done", e.id);
      sb.delete();
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int d0;
    rst_n = 1'b0; job_valid = 1'b0; load_mode = 1'b0; load_valid = 1'b0;
    load_addr = '0; load_data = 1'b0;
    job_ix0 = '0; job_iy0 = '0; job_iz0 = '0; job_sx = 1'b0; job_sy = 1'b0; job_sz = 1'b0;
    job_next_x = '0; job_next_y = '0; job_next_z = '0;
    job_inc_x = '0; job_inc_y = '0; job_inc_z = '0; job_max_steps = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_job_ready", int'(job_ready), 1);
    chk("rst_load_ready", int'(load_ready), 0);
    chk("rst_ray_done", int'(ray_done), 0);
    chk("rst_ray_hit", int'(ray_hit), 0);
    chk("rst_ray_timeout", int'(ray_timeout), 0);
    chk("rst_steps", int'(steps_taken), 0);
    chk("rst_face", int'(hit_face_id), 0);
    chk("rst_write_count", int'(write_count), 0);
    chk("rst_load_complete", int'(load_complete), 0);

    // Full scene clear over every address
    load_mode = 1'b1;
    for (int i = 0; i < 32768; i++) wr(i, 1'b0);
    load_valid = 1'b0;
    chk("load_job_ready", int'(job_ready), 0);
    chk("load_ready", int'(load_ready), 1);
    chk("full_write_count", int'(write_count), 32768);
    chk("full_load_complete", int'(load_complete), 1);
    wr(0, 1'b0);
    load_valid = 1'b0;
    chk("sat_write_count", int'(write_count), 32768);
    load_mode = 1'b0;
    @(negedge clk);
    chk("hold_write_count", int'(write_count), 32768);
    chk("idle_job_ready", int'(job_ready), 1);

    // Exit +X without wrapping
    scene(va(0,0,0), va(0,15,15));
    run_job(31,15,15, 1,1,1, 100,1000,1000, 100,200,200, 10, 0,0,0,0,0, 0,1,3);
    // Exit -X without wrapping
    scene(va(0,15,15), va(31,15,15));
    run_job(0,15,15, 0,1,1, 100,1000,1000, 100,200,200, 10, 0,0,0,0,0, 0,1,3);
    // Hits along each positive axis
    scene(va(31,15,15), va(15,10,10));
    run_job(10,10,10, 1,1,1, 100,1000,1000, 100,200,200, 50, 1,0,15,10,10, 0,5,17);
    scene(va(15,10,10), va(10,18,10));
    run_job(10,10,10, 1,1,1, 1000,100,1000, 200,100,200, 50, 1,0,10,18,10, 2,8,26);
    scene(va(10,18,10), va(10,10,20));
    run_job(10,10,10, 1,1,1, 10000,10000,100, 2000,2000,50, 50, 1,0,10,10,20, 4,10,32);
    // Solid start voxel
    scene(va(10,10,20), va(12,12,12));
    run_job(12,12,12, 1,1,1, 100,1000,1000, 100,200,200, 50, 1,0,12,12,12, 6,0,2);
    scene(va(12,12,12), va(5,10,10));
    run_job(0,10,10, 1,1,1, 100,1000,1000, 100,200,200, 50, 1,0,5,10,10, 0,5,17);
    // Timeouts, out-of-grid start, tie-break towards X with negative step
    scene(va(5,10,10), va(19,20,20));
    run_job(10,10,10, 1,1,1, 100,1000,1000, 100,200,200, 3, 0,1,0,0,0, 0,3,11);
    run_job(10,10,10, 1,1,1, 100,1000,1000, 100,200,200, 0, 0,1,0,0,0, 0,0,2);
    run_job(40,0,0, 1,1,1, 100,1000,1000, 100,200,200, 50, 0,0,0,0,0, 0,0,0);
    run_job(20,20,20, 0,0,0, 500,500,500, 10,1000,1000, 50, 1,0,19,20,20, 1,1,5);
    // Y over Z on a tie, negative step
    scene(va(19,20,20), va(20,19,20));
    run_job(20,20,20, 0,0,0, 900,500,500, 10,1000,1000, 50, 1,0,20,19,20, 3,1,5);
    scene(va(20,19,20), va(20,20,19));
    run_job(20,20,20, 0,0,0, 900,900,500, 10,1000,1000, 50, 1,0,20,20,19, 5,1,5);
    // Timer saturation: X timer must clamp to all-ones so Y moves next
    scene(va(20,20,19), va(21,21,20));
    run_job(20,20,20, 1,1,1, 32'hFFFF_FF00,32'hFFFF_FFFE,32'hFFFF_FFFF, 32'h200,1,1, 50,
            1,0,21,21,20, 2,2,8);

    // Reset mid-ray aborts without a completion pulse
    scene(va(21,21,20), va(21,21,20));
    d0 = done_cnt;
    job_ix0 = 6'd0; job_iy0 = 6'd0; job_iz0 = 6'd0;
    job_sx = 1'b1; job_sy = 1'b1; job_sz = 1'b1;
    job_next_x = 32'd1; job_next_y = 32'd1000; job_next_z = 32'd1000;
    job_inc_x = 32'd1; job_inc_y = 32'd1000; job_inc_z = 32'd1000;
    job_max_steps = 10'd500;
    job_valid = 1'b1;
    @(posedge clk);
    #1 job_valid = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (150) @(negedge clk);
    chk("abort_no_done", done_cnt - d0, 0);
    chk("abort_job_ready", int'(job_ready), 1);
    chk("abort_steps", int'(steps_taken), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/raytracer_top.md
Name: raytracer_top

Overview:
Voxel ray-traversal engine with an on-chip 32x32x32 occupancy memory (1 bit per voxel).
- A load port fills the scene.
- A job port accepts one ray in 3D-DDA form: start voxel, step signs, initial axis timers, per-axis timer increments and a step limit.
- The engine walks voxels until it hits a solid voxel, leaves the grid, or exhausts the step budget, then reports the result.
- Top of the ray-tracing accelerator; the host/job generator drives it.

Parameters:
COORD_WIDTH 16 width of hit_voxel_* outputs (zero-extended)
COORD_W 6 internal coordinate width (one guard bit beyond 0..31)
TIMER_WIDTH 32 internal axis timer width
W 32 width of job timer/increment inputs
MAX_VAL 31 largest legal coordinate
ADDR_BITS 15 voxel memory address width (32768 entries)
X_BITS 6 job_ix0 width; Y_BITS 6 job_iy0 width; Z_BITS 6 job_iz0 width
MAX_STEPS_BITS 10 job_max_steps width
STEP_COUNT_WIDTH 16 steps_taken width

Ports:
clk in 1 clock
rst_n in 1 reset, synchronous, active-low
job_valid in 1 job offer; job_ready out 1 engine can accept a job
job_ix0/job_iy0/job_iz0 in X/Y/Z_BITS start voxel
job_sx/job_sy/job_sz in 1 step direction per axis (1 = +1, 0 = -1)
job_next_x/y/z in W initial axis timers (tMax)
job_inc_x/y/z in W per-axis timer increments (tDelta)
job_max_steps in MAX_STEPS_BITS step budget
load_mode in 1 scene-load mode; load_valid in 1 write strobe; load_ready out 1 write accepted
load_addr in ADDR_BITS voxel address {z[4:0],y[4:0],x[4:0]}; load_data in 1 occupancy bit
write_count out ADDR_BITS+1 writes since load_mode rose; load_complete out 1 write_count == 32768
ray_done out 1 one-cycle completion pulse; ray_hit out 1 solid voxel hit; ray_timeout out 1 step budget exhausted
hit_voxel_x/y/z out COORD_WIDTH hit voxel coordinates
hit_face_id out 3 face entered; steps_taken out STEP_COUNT_WIDTH steps performed

Behaviour:
Reset and handshakes:
- Clock and reset: single clock clk; reset rst_n is synchronous and active-low.
- Reset: all outputs 0 except job_ready. FSM returns to IDLE. Memory contents are undefined (not cleared).
- load_ready = load_mode && FSM in IDLE.
- Write to mem[load_addr] <= load_data on load_valid && load_ready.
- write_count clears on the rising edge of load_mode, then increments per accepted write, saturating at 32768, and holds after load_mode falls.
- job_ready = IDLE && !load_mode. Accept on job_valid && job_ready: latch all job fields, zero-extend coords to COORD_W, zero-extend timers to TIMER_WIDTH, clear step counter, clear ray_hit, ray_timeout and hit_face_id.

FSM IDLE -> FETCH -> CHECK -> (STEP -> FETCH)* -> DONE -> IDLE:
- FETCH: drive memory address {z,y,x}. Memory read is synchronous, 1-cycle latency.
- CHECK, in priority order:
  - If the voxel is solid: ray_hit=1, hit_voxel_* = current coordinates, hit_face_id = last-step face, go to DONE.
  - Else if step count == max_steps: ray_timeout=1, go to DONE.
  - Else go to STEP.
- STEP:
  - Select the axis with the smallest timer (unsigned). Ties go to X over Y over Z.
  - Move that coordinate by +1/-1 per its sign bit. Add inc to that axis timer, saturating at all-ones.
  - Increment the step count. Record face: X+ = 0, X- = 1, Y+ = 2, Y- = 3, Z+ = 4, Z- = 5.
  - If the new coordinate is > MAX_VAL (31 -> 32, or 0 -> 63 after 6-bit decrement): out of bounds. Go to DONE with ray_hit=0, ray_timeout=0. Never wrap and never read memory.
  - Else go to FETCH.
- DONE: ray_done=1 for exactly one cycle, then return to IDLE. ray_hit, ray_timeout, hit_voxel_*, hit_face_id and steps_taken hold until the next job is accepted.

Boundary cases:
- Start voxel solid: hit at the start position, steps_taken=0, hit_face_id=6 (no face entered).
- Start coordinate > 31: immediate DONE with no hit, no timeout, steps 0.
- max_steps=0: only the start voxel is checked; timeout if it is empty.
- steps_taken reports the final step count for every outcome.
- Reset mid-ray aborts the ray with no ray_done pulse.
- job_valid while busy or in load_mode is ignored.

Timing: 3 cycles per step. ray_done asserts one cycle after the final CHECK or the out-of-bounds STEP.

Test Plan:
- Empty grid except solid at (0,15,15); ray from (31,15,15), signs +,+,+, next=(100,1000,1000), inc=(100,200,200), max=10 -> ray_done, ray_hit=0, ray_timeout=0 (exits, no wrap).
- Solid only at (31,15,15); ray from (0,15,15), sx=0, same timers -> no hit, no timeout.
- Solid at (15,10,10); ray from (10,10,10) +X, max=50 -> hit (15,10,10), face 0, steps 5. Same with solid at (10,18,10), timers (1000,100,1000)/(200,100,200) -> hit y=18, face 2. Solid at (10,10,20), timers (10000,10000,100)/(2000,2000,50) -> hit z=20, face 4, steps 10.
- Solid at (12,12,12); ray starts there -> hit (12,12,12), steps 0, face 6.
- Solid at (5,10,10); ray from (0,10,10) +X -> hit (5,10,10), face 0. Empty grid, max=3, all inside -> ray_timeout=1, steps 3.
- Load all 32768 addresses -> write_count=32768, load_complete=1. job_ready=0 while load_mode=1.
